// File: rtl/subleq_ctrl_pkg.sv
// Shared definitions for the SUBLEQ sequencer and mmio: word width, FSM state
// encoding, the reserved I/O addresses and the branch-condition helper.
package subleq_ctrl_pkg;

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

    localparam int W = `WORD_SIZE;

    typedef logic [W-1:0] word_t;

    typedef enum logic [2:0] {
        S_FETCH_A = 3'd0,
        S_FETCH_B = 3'd1,
        S_FETCH_C = 3'd2,
        S_READ_A  = 3'd3,
        S_READ_B  = 3'd4,
        S_WRITE_B = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // Top three addresses are decoded by mmio: halt, output port, input port.
    localparam word_t ADDR_HALT = {W{1'b1}};
    localparam word_t ADDR_OUT  = ADDR_HALT - word_t'(1);
    localparam word_t ADDR_IN   = ADDR_HALT - word_t'(2);

    // SUBLEQ branches when the result is signed <= 0.
    function automatic logic is_le_zero(input word_t r);
        return r[W-1] | (r == '0);
    endfunction

endpackage

// File: rtl/subleq_ctrl_if.sv
// Sequencer <-> mmio bus: access address, direction, write data, read data and
// the combinational halt request.
interface subleq_ctrl_if;
    import subleq_ctrl_pkg::*;

    word_t addr;
    logic  load;
    word_t data_out;
    word_t data_in;
    logic  halt;

    modport master (output addr, load, data_out, input data_in, halt);
    modport slave  (input addr, load, data_out, output data_in, halt);
endinterface

// File: rtl/subleq_ctrl_alu.sv
// SUBLEQ arithmetic: r = vb - va (mod 2^W) plus the signed <= 0 branch flag.
module subleq_ctrl_alu
    import subleq_ctrl_pkg::*;
(
    input  word_t i_va,
    input  word_t i_vb,
    output word_t o_r,
    output logic  o_le
);
    assign o_r  = i_vb - i_va;
    assign o_le = is_le_zero(o_r);
endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer: six-cycle fetch/read/write FSM driving mmio.
// Define SUBLEQ_STEP_EN to add a step input that gates each instruction.
module subleq_ctrl
    import subleq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
`ifdef SUBLEQ_STEP_EN
    input  logic          step,
`endif
    subleq_ctrl_if.master bus,
    output word_t         pc,
    output logic          halted
);
    state_t r_state;
    state_t w_state_next;
    word_t  r_pc, r_a, r_b, r_c, r_va, r_vb;
    word_t  w_r;
    logic   w_le;
    logic   w_go;

`ifdef SUBLEQ_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    subleq_ctrl_alu u_alu (
        .i_va (r_va),
        .i_vb (r_vb),
        .o_r  (w_r),
        .o_le (w_le)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state != S_HALT && bus.halt) begin
            w_state_next = S_HALT;
        end else begin
            case (r_state)
                S_FETCH_A: if (w_go) w_state_next = S_FETCH_B;
                S_FETCH_B: w_state_next = S_FETCH_C;
                S_FETCH_C: w_state_next = S_READ_A;
                S_READ_A:  w_state_next = S_READ_B;
                S_READ_B:  w_state_next = S_WRITE_B;
                S_WRITE_B: w_state_next = S_FETCH_A;
                default:   w_state_next = S_HALT;
            endcase
        end
    end

    // A cycle that raises halt must leave every register untouched, pc included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= '0;
            r_va <= '0;
            r_vb <= '0;
        end else if (!bus.halt) begin
            case (r_state)
                S_FETCH_A: if (w_go) r_a <= bus.data_in;
                S_FETCH_B: r_b  <= bus.data_in;
                S_FETCH_C: r_c  <= bus.data_in;
                S_READ_A:  r_va <= bus.data_in;
                S_READ_B:  r_vb <= bus.data_in;
                S_WRITE_B: r_pc <= w_le ? r_c : r_pc + word_t'(3);
                default:   ;
            endcase
        end
    end

    always_comb begin
        bus.addr     = '0;
        bus.load     = 1'b1;
        bus.data_out = '0;
        halted       = 1'b0;
        case (r_state)
            S_FETCH_A: bus.addr = r_pc;
            S_FETCH_B: bus.addr = r_pc + word_t'(1);
            S_FETCH_C: bus.addr = r_pc + word_t'(2);
            S_READ_A:  bus.addr = r_a;
            S_READ_B:  bus.addr = r_b;
            S_WRITE_B: begin
                bus.addr     = r_b;
                bus.load     = 1'b0;
                bus.data_out = w_r;
            end
            S_HALT:    halted = 1'b1;
            default:   ;
        endcase
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Self-checking bench for subleq_ctrl (W=8) with a behavioural mmio/memory
// model and a write scoreboard; step tests build only with SUBLEQ_STEP_EN.
module tb_subleq_ctrl;
    import subleq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef SUBLEQ_STEP_EN
    logic step = 1'b1;
`endif
    word_t pc;
    logic  halted;

    subleq_ctrl_if bus();

    subleq_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef SUBLEQ_STEP_EN
        .step   (step),
`endif
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Behavioural mmio: RAM plus input/output/halt addresses.
    localparam logic [7:0] IN_VAL = 8'h05;
    logic [7:0] prog_img [256];
    logic [7:0] mem [256];
    logic [7:0] out_val;

    assign bus.halt = (bus.addr == ADDR_HALT);

    always_comb begin
        if (bus.addr == ADDR_IN)       bus.data_in = IN_VAL;
        else if (bus.addr == ADDR_OUT) bus.data_in = 8'h00;
        else                           bus.data_in = mem[bus.addr];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog_img[i];
            out_val <= 8'h00;
        end else if (!bus.load && !bus.halt) begin
            if (bus.addr == ADDR_OUT) out_val <= bus.data_out;
            else                      mem[bus.addr] <= bus.data_out;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb_q[$];
    wr_t sb_e;

    // Every write cycle the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && !bus.load) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.addr, bus.data_out);
            end else begin
                sb_e = sb_q.pop_front();
                if (bus.addr !== sb_e.addr || bus.data_out !== sb_e.data) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.addr, bus.data_out, sb_e.addr, sb_e.data);
                end else begin
                    $display("write addr=%h data=%h ok", bus.addr, bus.data_out);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] p0, p1, p2, p3, p4, p5;
        logic [7:0] exp_addr, exp_data, exp_pc;
    } vec_t;

    function automatic vec_t mk(input string n,
                                input logic [7:0] p0, p1, p2, p3, p4, p5,
                                input logic [7:0] ea, ed, ep);
        vec_t v;
        v.name = n;
        v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.p4 = p4; v.p5 = p5;
        v.exp_addr = ea; v.exp_data = ed; v.exp_pc = ep;
        return v;
    endfunction

    task automatic start_prog(input logic [7:0] p0, p1, p2, p3, p4, p5);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) prog_img[i] = 8'h00;
        prog_img[0] = p0; prog_img[1] = p1; prog_img[2] = p2;
        prog_img[3] = p3; prog_img[4] = p4; prog_img[5] = p5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from reset; returns at the negedge of the next FETCH_A.
    task automatic run_one(input vec_t v);
        wr_t e;
        start_prog(v.p0, v.p1, v.p2, v.p3, v.p4, v.p5);
        chk({v.name, "_fetch_addr"}, bus.addr, 8'h00);
        chk({v.name, "_fetch_load"}, bus.load, 1'b1);
        e.addr = v.exp_addr;
        e.data = v.exp_data;
        sb_q.push_back(e);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({v.name, "_wb_load"}, bus.load, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "_pc"}, pc, v.exp_pc);
        chk({v.name, "_next_addr"}, bus.addr, v.exp_pc);
        if (v.exp_addr == ADDR_OUT) chk({v.name, "_out"}, out_val, v.exp_data);
        else                        chk({v.name, "_mem"}, mem[v.exp_addr], v.exp_data);
        $display("vector %s: pc=%h", v.name, pc);
    endtask

    vec_t vecs [8];

    initial begin
        wr_t e;
        vecs[0] = mk("branch_taken", 8'd3, 8'd4, 8'd6, 8'd5,    8'd2,    8'd0, 8'd4,    8'hFD, 8'd6);
        vecs[1] = mk("not_taken",    8'd3, 8'd4, 8'd6, 8'd1,    8'd5,    8'd0, 8'd4,    8'h04, 8'd3);
        vecs[2] = mk("output",       8'd3, 8'hFE,8'd0, 8'hBF,   8'd0,    8'd0, 8'hFE,   8'h41, 8'd3);
        vecs[3] = mk("zero_branch",  8'd5, 8'd5, 8'd9, 8'd0,    8'd0,    8'd7, 8'd5,    8'h00, 8'd9);
        vecs[4] = mk("neg_branch",   8'd3, 8'd4, 8'd7, 8'h80,   8'h00,   8'd0, 8'd4,    8'h80, 8'd7);
        vecs[5] = mk("msb_branch",   8'd3, 8'd4, 8'd7, 8'h01,   8'h81,   8'd0, 8'd4,    8'h80, 8'd7);
        vecs[6] = mk("pos_7f",       8'd3, 8'd4, 8'd7, 8'h01,   8'h80,   8'd0, 8'd4,    8'h7F, 8'd3);
        vecs[7] = mk("input",        8'hFD,8'd4, 8'd9, 8'd0,    8'h10,   8'd0, 8'd4,    8'h0B, 8'd3);
        for (int i = 0; i < 256; i++) prog_img[i] = 8'h00;

        // Reset held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", bus.addr, 8'h00);
        chk("rst_load", bus.load, 1'b1);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 1'b0);

        for (int i = 0; i < 8; i++) run_one(vecs[i]);

        // Halt: r=0 branches to 0xFF, then stays halted.
        start_prog(8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0);
        e.addr = 8'h00; e.data = 8'h00;
        sb_q.push_back(e);
        repeat (5) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("halt_pc_ff", pc, 8'hFF);
        chk("halt_fetch_addr", bus.addr, 8'hFF);
        chk("halt_not_yet", halted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("halt_halted", halted, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("halt_hold_halted", halted, 1'b1);
            chk("halt_hold_pc", pc, 8'hFF);
            chk("halt_hold_load", bus.load, 1'b1);
            chk("halt_hold_addr", bus.addr, 8'h00);
        end
        chk("halt_data_out", bus.data_out, 8'h00);
        $display("halt sequence: halted=%b pc=%h", halted, pc);

        // pc wrap: jump to 0xFE, FETCH_B at 0xFF halts with pc=0xFE.
        start_prog(8'h10, 8'h10, 8'hFE, 8'd0, 8'd0, 8'd0);
        e.addr = 8'h10; e.data = 8'h00;
        sb_q.push_back(e);
        repeat (5) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_pc", pc, 8'hFE);
        chk("wrap_fetch_a", bus.addr, 8'hFE);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_fetch_b", bus.addr, 8'hFF);
        chk("wrap_not_halted", halted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_halted", halted, 1'b1);
        chk("wrap_pc_hold", pc, 8'hFE);
        $display("wrap sequence: halted=%b pc=%h", halted, pc);

        // Asynchronous reset from a halted, non-zero state.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 8'h00);
        chk("arst_halted", halted, 1'b0);
        chk("arst_addr", bus.addr, 8'h00);

        // Reset asserted in WRITE_B drops load without waiting for a clock.
        start_prog(8'd3, 8'd4, 8'd6, 8'd5, 8'd2, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_wb_load", bus.load, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_load", bus.load, 1'b1);
        chk("mid_rst_addr", bus.addr, 8'h00);
        chk("mid_rst_data_out", bus.data_out, 8'h00);
        $display("mid-write reset: load=%b", bus.load);

`ifdef SUBLEQ_STEP_EN
        step = 1'b0;
        start_prog(8'd3, 8'd4, 8'd6, 8'd5, 8'd2, 8'd0);
        for (int i = 0; i < 20; i++) begin
            chk("step_hold_addr", bus.addr, 8'h00);
            chk("step_hold_pc", pc, 8'h00);
            @(posedge clk);
            @(negedge clk);
        end
        e.addr = 8'h04; e.data = 8'hFD;
        sb_q.push_back(e);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("step_wb_load", bus.load, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("step_pc", pc, 8'h06);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("step_rehold_addr", bus.addr, 8'h06);
        end
        $display("step sequence: pc=%h", pc);
        step = 1'b1;
`endif

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
